// File: rtl/decoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq_if
// Description : Bundle of control, address and decode signals for decoder_seq.
//               master - drives e, ld, mode, a, hold; observes y, addr, busy, wrap
//               slave  - the decoder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface decoder_seq_if #(
    parameter int N      = 2,
    parameter int HOLD_W = 4
);
    logic                 e;
    logic                 ld;
    logic                 mode;
    logic [N-1:0]         a;
    logic [HOLD_W-1:0]    hold;
    logic [(1<<N)-1:0]    y;
    logic [N-1:0]         addr;
    logic                 busy;
    logic                 wrap;

    modport master (
        output e, ld, mode, a, hold,
        input  y, addr, busy, wrap
    );

    modport slave (
        input  e, ld, mode, a, hold,
        output y, addr, busy, wrap
    );
endinterface
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq
// Description : Registered N-to-2^N one-hot decoder with enable.
//               DIRECT mode decodes and holds a loaded address; SCAN mode
//               steps the address every hold+1 cycles and pulses wrap when
//               the address rolls over to 0.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - decoder_seq_if.slave (e, ld, mode, a, hold -> y, addr,
//                      busy, wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq #(
    parameter int N          = 2,
    parameter int HOLD_W     = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst,
    decoder_seq_if.slave       bus
);
    localparam int W = 1 << N;

    // XOR mask that turns an active-high one-hot into the output polarity.
    localparam logic [W-1:0] C_INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t              r_state;
    logic [N-1:0]        r_addr;
    logic [HOLD_W-1:0]   r_cnt;
    logic [HOLD_W-1:0]   r_held;
    logic [W-1:0]        r_y;
    logic                r_busy;
    logic                r_wrap;

    logic [N-1:0]        w_addr_next;

    assign w_addr_next = r_addr + N'(1);

    function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
        onehot = W'(1) << v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_held  <= '0;
            r_y     <= C_INACTIVE;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!bus.e) begin
            // Disable wins over load; addr and held dwell are retained.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_y     <= C_INACTIVE;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (bus.ld) begin
            // A load behaves identically from every state.
            r_addr  <= bus.a;
            r_held  <= bus.hold;
            r_cnt   <= '0;
            r_state <= bus.mode ? S_SCAN : S_DIRECT;
            r_y     <= onehot(bus.a) ^ C_INACTIVE;
            r_busy  <= bus.mode;
            r_wrap  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_y    <= C_INACTIVE;
                    r_busy <= 1'b0;
                    r_wrap <= 1'b0;
                end
                S_DIRECT: begin
                    r_wrap <= 1'b0;
                end
                S_SCAN: begin
                    if (r_cnt == r_held) begin
                        // Step: y and addr move together so they never disagree.
                        r_cnt  <= '0;
                        r_addr <= w_addr_next;
                        r_y    <= onehot(w_addr_next) ^ C_INACTIVE;
                        r_wrap <= (w_addr_next == '0);
                    end else begin
                        r_cnt  <= r_cnt + HOLD_W'(1);
                        r_wrap <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_y     <= C_INACTIVE;
                    r_busy  <= 1'b0;
                    r_wrap  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y    = r_y;
    assign bus.addr = r_addr;
    assign bus.busy = r_busy;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_seq
// Description : Directed bench for decoder_seq. Instance 0: N=2, active-high.
//               Instance 1: N=3, ACTIVE_LOW=1. Expected outputs are queued
//               per step and compared once the DUT has registered them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;
    logic clk;
    logic rst;

    decoder_seq_if #(.N(2), .HOLD_W(4)) bus0 ();
    decoder_seq_if #(.N(3), .HOLD_W(4)) bus1 ();

    decoder_seq #(.N(2), .HOLD_W(4), .ACTIVE_LOW(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    decoder_seq #(.N(3), .HOLD_W(4), .ACTIVE_LOW(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         idx;
        logic [7:0] y;
        logic [2:0] addr;
        logic       busy;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input string tag, input int idx, input logic [7:0] y,
                        input logic [2:0] addr, input logic busy, input logic wrap);
        exp_t e;
        e.tag = tag; e.idx = idx; e.y = y; e.addr = addr; e.busy = busy; e.wrap = wrap;
        sb.push_back(e);
    endtask

    task automatic check_one(input string tag, input string field,
                             input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        logic [7:0] oy, oa;
        logic       ob, ow;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        if (e.idx == 0) begin
            oy = {4'b0000, bus0.y}; oa = {6'b0, bus0.addr}; ob = bus0.busy; ow = bus0.wrap;
        end else begin
            oy = bus1.y; oa = {5'b0, bus1.addr}; ob = bus1.busy; ow = bus1.wrap;
        end
        check_one(e.tag, "y",    oy,          e.y);
        check_one(e.tag, "addr", oa,          {5'b0, e.addr});
        check_one(e.tag, "busy", {7'b0, ob},  {7'b0, e.busy});
        check_one(e.tag, "wrap", {7'b0, ow},  {7'b0, e.wrap});
    endtask

    // Queue an expectation, let one clock edge pass, then compare 1 time unit later.
    task automatic cyc(input string tag, input int idx, input logic [7:0] y,
                       input logic [2:0] addr, input logic busy, input logic wrap);
        push(tag, idx, y, addr, busy, wrap);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic drv0(input logic e, input logic ld, input logic mode,
                        input logic [1:0] a, input logic [3:0] hold);
        bus0.e = e; bus0.ld = ld; bus0.mode = mode; bus0.a = a; bus0.hold = hold;
    endtask

    initial begin
        rst = 1'b1;
        drv0(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        bus1.e = 1'b0; bus1.ld = 1'b0; bus1.mode = 1'b0; bus1.a = 3'd0; bus1.hold = 4'd0;

        // Reset state, observed before any clock edge.
        #1;
        push("reset0", 0, 8'h00, 3'd0, 1'b0, 1'b0); pop_check();
        push("reset1", 1, 8'hFF, 3'd0, 1'b0, 1'b0); pop_check();
        @(posedge clk); #1;
        rst = 1'b0;

        // DIRECT sweep.
        drv0(1'b1, 1'b1, 1'b0, 2'd0, 4'd0); cyc("dir_a0", 0, 8'b0001, 3'd0, 1'b0, 1'b0);
        drv0(1'b1, 1'b1, 1'b0, 2'd1, 4'd0); cyc("dir_a1", 0, 8'b0010, 3'd1, 1'b0, 1'b0);
        drv0(1'b1, 1'b1, 1'b0, 2'd2, 4'd0); cyc("dir_a2", 0, 8'b0100, 3'd2, 1'b0, 1'b0);
        drv0(1'b1, 1'b1, 1'b0, 2'd3, 4'd0); cyc("dir_a3", 0, 8'b1000, 3'd3, 1'b0, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd0, 4'd0); cyc("dir_hold", 0, 8'b1000, 3'd3, 1'b0, 1'b0);
        drv0(1'b1, 1'b1, 1'b0, 2'd2, 4'd0); cyc("dir_re2", 0, 8'b0100, 3'd2, 1'b0, 1'b0);

        // Enable gating: e=0 beats ld=1.
        drv0(1'b0, 1'b1, 1'b0, 2'd3, 4'd0); cyc("gate_off", 0, 8'b0000, 3'd2, 1'b0, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd3, 4'd0); cyc("gate_on1", 0, 8'b0000, 3'd2, 1'b0, 1'b0);
        cyc("gate_on2", 0, 8'b0000, 3'd2, 1'b0, 1'b0);

        // SCAN with hold=0: one step per cycle, wrap on the step to 0.
        drv0(1'b1, 1'b1, 1'b1, 2'd2, 4'd0); cyc("scan0_ld", 0, 8'b0100, 3'd2, 1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        cyc("scan0_s1", 0, 8'b1000, 3'd3, 1'b1, 1'b0);
        cyc("scan0_s2", 0, 8'b0001, 3'd0, 1'b1, 1'b1);
        cyc("scan0_s3", 0, 8'b0010, 3'd1, 1'b1, 1'b0);
        cyc("scan0_s4", 0, 8'b0100, 3'd2, 1'b1, 1'b0);

        // SCAN with hold=2: each value for 3 cycles; hold change mid-scan ignored.
        drv0(1'b1, 1'b1, 1'b1, 2'd0, 4'd2); cyc("scan2_ld", 0, 8'b0001, 3'd0, 1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd0, 4'd2);
        cyc("scan2_d1", 0, 8'b0001, 3'd0, 1'b1, 1'b0);
        cyc("scan2_d2", 0, 8'b0001, 3'd0, 1'b1, 1'b0);
        cyc("scan2_s1", 0, 8'b0010, 3'd1, 1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        cyc("scan2_h1", 0, 8'b0010, 3'd1, 1'b1, 1'b0);
        cyc("scan2_h2", 0, 8'b0010, 3'd1, 1'b1, 1'b0);
        cyc("scan2_s2", 0, 8'b0100, 3'd2, 1'b1, 1'b0);
        cyc("scan2_s2b", 0, 8'b0100, 3'd2, 1'b1, 1'b0);
        drv0(1'b1, 1'b1, 1'b1, 2'd3, 4'd2); cyc("scan2_rl", 0, 8'b1000, 3'd3, 1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        cyc("scan2_r1", 0, 8'b1000, 3'd3, 1'b1, 1'b0);
        cyc("scan2_r2", 0, 8'b1000, 3'd3, 1'b1, 1'b0);
        cyc("scan2_wr", 0, 8'b0001, 3'd0, 1'b1, 1'b1);
        cyc("scan2_aw", 0, 8'b0001, 3'd0, 1'b1, 1'b0);
        // Load to a=0 from SCAN must not raise wrap.
        drv0(1'b1, 1'b1, 1'b1, 2'd0, 4'd0); cyc("scan_ld0", 0, 8'b0001, 3'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a scan at addr=2.
        drv0(1'b1, 1'b1, 1'b1, 2'd2, 4'd2); cyc("rst_pre", 0, 8'b0100, 3'd2, 1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 2'd0, 4'd2);
        #1;
        rst = 1'b1;
        #1;
        push("rst_async", 0, 8'b0000, 3'd0, 1'b0, 1'b0); pop_check();
        drv0(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("rst_post1", 0, 8'b0000, 3'd0, 1'b0, 1'b0);
        cyc("rst_post2", 0, 8'b0000, 3'd0, 1'b0, 1'b0);

        // ACTIVE_LOW, N=3.
        bus1.e = 1'b1; bus1.ld = 1'b1; bus1.mode = 1'b0; bus1.a = 3'd5;
        cyc("al_dir5", 1, 8'b11011111, 3'd5, 1'b0, 1'b0);
        bus1.e = 1'b0; bus1.ld = 1'b0;
        cyc("al_off", 1, 8'hFF, 3'd5, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
